// File: rtl/fir_channel_scheduler_if.sv
// Bundle of request, FIR engine and consumer signals for fir_channel_scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface fir_channel_scheduler_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 24
);
  localparam int CH_BITS = $clog2(N_CH);

  logic [N_CH-1:0]       iv_req_valid;
  logic [N_CH*WIDTH-1:0] iv_req_data;
  logic [N_CH-1:0]       ov_req_ready;
  logic [WIDTH-1:0]      ov_fir_din;
  logic [CH_BITS-1:0]    ov_fir_ch;
  logic                  o_fir_din_valid;
  logic                  i_fir_ready;
  logic [WIDTH-1:0]      iv_fir_dout;
  logic                  i_fir_dout_valid;
  logic [WIDTH-1:0]      ov_dout;
  logic [CH_BITS-1:0]    ov_dout_ch;
  logic                  o_dout_valid;
  logic                  i_dout_ready;
  logic                  o_err;
  logic [CH_BITS-1:0]    ov_err_ch;
  logic                  o_busy;

  modport slave (
    input  iv_req_valid, iv_req_data, i_fir_ready, iv_fir_dout, i_fir_dout_valid,
           i_dout_ready,
    output ov_req_ready, ov_fir_din, ov_fir_ch, o_fir_din_valid, ov_dout, ov_dout_ch,
           o_dout_valid, o_err, ov_err_ch, o_busy
  );

  modport master (
    output iv_req_valid, iv_req_data, i_fir_ready, iv_fir_dout, i_fir_dout_valid,
           i_dout_ready,
    input  ov_req_ready, ov_fir_din, ov_fir_ch, o_fir_din_valid, ov_dout, ov_dout_ch,
           o_dout_valid, o_err, ov_err_ch, o_busy
  );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler multiplexing N_CH serial channels onto one FIR engine,
// with one sample in flight, a result timeout and a held consumer output.
module fir_channel_scheduler #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 64
) (
  input logic                   i_clk,
  input logic                   i_rst,
  input logic                   i_en,
  fir_channel_scheduler_if.slave bus
);
  localparam int CH_BITS = $clog2(N_CH);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ISSUE   = 4'b0010,
    WAIT    = 4'b0100,
    DELIVER = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic [CH_BITS-1:0] rr_q, rr_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic [CH_BITS-1:0] dout_ch_q, dout_ch_d;
  logic [CH_BITS-1:0] err_ch_q, err_ch_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               grant_any;
  logic [CH_BITS-1:0] grant_idx;

  function automatic logic [CH_BITS-1:0] next_ch(input logic [CH_BITS-1:0] ch);
    return (int'(ch) == N_CH - 1) ? '0 : ch + CH_BITS'(1);
  endfunction

  // First valid channel at or above rr_q, wrapping past N_CH-1 back to 0.
  always_comb begin : grant_search
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_CH) idx -= N_CH;
      if (!grant_any && bus.iv_req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = CH_BITS'(idx);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    ch_d      = ch_q;
    din_d     = din_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    err_ch_d  = err_ch_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          din_d   = bus.iv_req_data[int'(grant_idx)*WIDTH +: WIDTH];
          ch_d    = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_fir_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A result on the timeout cycle still wins over the error.
        if (bus.i_fir_dout_valid) begin
          dout_d    = bus.iv_fir_dout;
          dout_ch_d = ch_q;
          state_d   = DELIVER;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          err_ch_d = ch_q;
          rr_d     = next_ch(ch_q);
          state_d  = IDLE;
        end
      end
      DELIVER: begin
        if (bus.i_dout_ready) begin
          rr_d    = next_ch(ch_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; reset beats enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      ch_q      <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      err_ch_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else if (i_en) begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      ch_q      <= ch_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      err_ch_q  <= err_ch_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.ov_req_ready    = (state_q == IDLE && grant_any && !i_rst)
                               ? (N_CH'(1) << grant_idx) : '0;
  assign bus.ov_fir_din      = din_q;
  assign bus.ov_fir_ch       = ch_q;
  assign bus.o_fir_din_valid = (state_q == ISSUE);
  assign bus.ov_dout         = dout_q;
  assign bus.ov_dout_ch      = dout_ch_q;
  assign bus.o_dout_valid    = (state_q == DELIVER);
  assign bus.o_err           = err_q;
  assign bus.ov_err_ch       = err_ch_q;
  assign bus.o_busy          = (state_q != IDLE);
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: directed requests push expected results
// or timeouts; a monitor pops and compares on every consumer transfer or error pulse.
module tb_fir_channel_scheduler;
  localparam int N_CH    = 4;
  localparam int WIDTH   = 24;
  localparam int TIMEOUT = 8;

  typedef struct {
    bit               is_err;
    int               ch;
    logic [WIDTH-1:0] data;
    int               gap;  // cycles since previous delivery, or timeout latency; 0 = unchecked
  } exp_t;

  exp_t             exp_q[$];
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b1;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               n_out    = 0;
  int               cyc      = 0;
  int               accept_cyc = 0;
  int               last_del_cyc = 0;
  int               eng_delay = 1;
  bit               hold_valid = 1'b0;
  bit               stray_req  = 1'b0;
  logic [N_CH-1:0]  pending = '0;
  logic [WIDTH-1:0] words [N_CH];

  fir_channel_scheduler_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

  fir_channel_scheduler #(.N_CH(N_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_res(input int ch, input logic [WIDTH-1:0] d, input int gap);
    exp_t e;
    e.is_err = 1'b0; e.ch = ch; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input int ch);
    exp_t e;
    e.is_err = 1'b1; e.ch = ch; e.data = '0; e.gap = TIMEOUT;
    exp_q.push_back(e);
  endtask

  task automatic apply_req();
    bus.iv_req_valid = pending;
    for (int c = 0; c < N_CH; c++) bus.iv_req_data[c*WIDTH +: WIDTH] = words[c];
  endtask

  // One clock: note accepted words at the negedge, retire them after the edge.
  task automatic step();
    logic [N_CH-1:0] acc;
    @(negedge clk);
    acc = bus.ov_req_ready & bus.iv_req_valid & {N_CH{en}};
    @(posedge clk);
    #1;
    if (!hold_valid) pending = pending & ~acc;
    apply_req();
  endtask

  task automatic wait_out(input int target, input int budget);
    int k;
    k = 0;
    while (n_out < target && k < budget) begin
      step();
      k++;
    end
    check("outputs_within_budget", 32'(n_out), 32'(target));
  endtask

  task automatic en_edge();
    @(posedge clk);
    while (!en) @(posedge clk);
  endtask

  // Engine model: always ready, echoes the accepted sample eng_delay enabled cycles later.
  initial begin : engine
    logic [WIDTH-1:0] sample;
    int               dly;
    bus.i_fir_ready      = 1'b1;
    bus.i_fir_dout_valid = 1'b0;
    bus.iv_fir_dout      = '0;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        @(posedge clk);
        #1;
        bus.iv_fir_dout      = 24'h000BAD;
        bus.i_fir_dout_valid = 1'b1;
        en_edge();
        #1;
        bus.i_fir_dout_valid = 1'b0;
      end else if (!rst && en && bus.o_fir_din_valid && bus.i_fir_ready) begin
        sample = bus.ov_fir_din;
        dly    = eng_delay;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (dly > 0) begin
          for (int k = 1; k < dly; k++) begin
            en_edge();
            #1;
          end
          bus.iv_fir_dout      = sample;
          bus.i_fir_dout_valid = 1'b1;
          en_edge();
          #1;
          bus.i_fir_dout_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: handshake legality every cycle, scoreboard compare on outputs.
  initial begin : monitor
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_legal",
              32'($countones(bus.ov_req_ready) <= 1 && (!bus.o_busy || bus.ov_req_ready == '0)),
              32'd1);
        if (bus.o_dout_valid) begin
          ok = exp_q.size() > 0 && !exp_q[0].is_err;
          check("dout_expected", 32'(ok), 32'd1);
          if (ok) begin
            check("dout_data", 32'(bus.ov_dout), 32'(exp_q[0].data));
            check("dout_ch", 32'(bus.ov_dout_ch), 32'(exp_q[0].ch));
            if (bus.i_dout_ready && en) begin
              if (exp_q[0].gap != 0) check("service_gap", 32'(cyc - last_del_cyc), 32'(exp_q[0].gap));
              last_del_cyc = cyc;
              void'(exp_q.pop_front());
              n_out++;
            end
          end
        end
        if (bus.o_err && en) begin
          ok = exp_q.size() > 0 && exp_q[0].is_err;
          check("err_expected", 32'(ok), 32'd1);
          if (ok) begin
            check("err_ch", 32'(bus.ov_err_ch), 32'(exp_q[0].ch));
            check("err_latency", 32'(cyc - accept_cyc), 32'(exp_q[0].gap));
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int base;
    for (int c = 0; c < N_CH; c++) words[c] = '0;
    bus.i_dout_ready = 1'b1;
    pending          = '1;
    apply_req();

    // Reset with every channel requesting: everything must read zero.
    repeat (3) step();
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_req_ready", 32'(bus.ov_req_ready), 32'd0);
    check("rst_fir_din_valid", 32'(bus.o_fir_din_valid), 32'd0);
    check("rst_dout_valid", 32'(bus.o_dout_valid), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_fir_din", 32'(bus.ov_fir_din), 32'd0);
    check("rst_fir_ch", 32'(bus.ov_fir_ch), 32'd0);
    check("rst_dout", 32'(bus.ov_dout), 32'd0);
    check("rst_dout_ch", 32'(bus.ov_dout_ch), 32'd0);
    check("rst_err_ch", 32'(bus.ov_err_ch), 32'd0);
    pending = '0;
    apply_req();
    rst = 1'b0;

    // All channels continuously valid: order 0,1,2,3,0 at 4 cycles per word.
    for (int c = 0; c < N_CH; c++) words[c] = 24'h000010 + 24'(c);
    expect_res(0, 24'h000010, 0);
    expect_res(1, 24'h000011, 4);
    expect_res(2, 24'h000012, 4);
    expect_res(3, 24'h000013, 4);
    expect_res(0, 24'h000010, 4);
    hold_valid = 1'b1;
    pending    = '1;
    apply_req();
    wait_out(5, 40);
    hold_valid = 1'b0;
    pending    = '0;
    apply_req();

    // rr_ptr=1: channel 2 alone, then channel 1 alone (search wraps from 3).
    words[2] = 24'h000222; pending = 4'b0100; apply_req();
    expect_res(2, 24'h000222, 0);
    wait_out(6, 20);
    words[1] = 24'h000111; pending = 4'b0010; apply_req();
    expect_res(1, 24'h000111, 0);
    wait_out(7, 20);
    // rr_ptr=2: channels 0 and 3 together -> 3 first, then 0.
    words[0] = 24'h000AAA; words[3] = 24'h000BBB; pending = 4'b1001; apply_req();
    expect_res(3, 24'h000BBB, 0);
    expect_res(0, 24'h000AAA, 4);
    wait_out(9, 30);

    // Engine silent: timeout on channel 1, then channel 2 is favoured over 1.
    eng_delay = 0;
    words[1] = 24'h00C0DE; pending = 4'b0010; apply_req();
    expect_err(1);
    wait_out(10, 30);
    eng_delay = 1;
    words[1] = 24'h001111; words[2] = 24'h002222; pending = 4'b0110; apply_req();
    expect_res(2, 24'h002222, 0);
    expect_res(1, 24'h001111, 4);
    wait_out(12, 30);
    check("err_ch_held", 32'(bus.ov_err_ch), 32'd1);

    // Result on the last counted cycle wins; one cycle later is a timeout.
    eng_delay = TIMEOUT;
    words[2] = 24'h0ABCDE; pending = 4'b0100; apply_req();
    expect_res(2, 24'h0ABCDE, 0);
    wait_out(13, 30);
    eng_delay = TIMEOUT + 1;
    words[3] = 24'h0F00F0; pending = 4'b1000; apply_req();
    expect_err(3);
    wait_out(14, 30);

    // Consumer stalls 10 cycles with enable toggling; channel 1 must wait.
    eng_delay        = 1;
    bus.i_dout_ready = 1'b0;
    words[0] = 24'h123456; words[1] = 24'h654321; pending = 4'b0011; apply_req();
    expect_res(0, 24'h123456, 0);
    expect_res(1, 24'h654321, 0);
    base = n_out;
    for (int k = 0; k < 20 && !bus.o_dout_valid; k++) step();
    check("deliver_reached", 32'(bus.o_dout_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      en = k[0];
      step();
    end
    en = 1'b1;
    check("stall_no_output", 32'(n_out), 32'(base));
    bus.i_dout_ready = 1'b1;
    step();
    check("first_ready_completes", 32'(n_out), 32'(base + 1));
    wait_out(base + 2, 20);

    // Reset while waiting on the engine, then a stray engine result.
    eng_delay = 0;
    words[2] = 24'h777777; pending = 4'b0100; apply_req();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    check("mid_rst_dout", 32'(bus.ov_dout), 32'd0);
    check("mid_rst_err_ch", 32'(bus.ov_err_ch), 32'd0);
    stray_req = 1'b1;
    step();
    stray_req = 1'b0;
    repeat (3) step();
    check("stray_ignored_busy", 32'(bus.o_busy), 32'd0);
    check("stray_ignored_dout_valid", 32'(bus.o_dout_valid), 32'd0);
    // rr_ptr back at 0: channel 1 before channel 3.
    eng_delay = 1;
    words[1] = 24'h0000A1; words[3] = 24'h0000A3; pending = 4'b1010; apply_req();
    expect_res(1, 24'h0000A1, 0);
    expect_res(3, 24'h0000A3, 4);
    wait_out(base + 4, 30);
    repeat (4) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
